// File: rtl/unified_mem_arbiter.sv
// Shares one memory port between fetch (IF) and data (DM); DM has priority, with a streak limit so IF is not starved.
// Latency is at least 2 cycles from req to ack; each requester sees stall_* until its one-cycle ack pulse.
module unified_mem_arbiter #(
    parameter int DM_STREAK_MAX = 4,
    parameter int TIMEOUT       = 15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    input  logic        clear_err,
    output logic        timeout_err
);

    localparam int SW = $clog2(DM_STREAK_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic [TW-1:0] tcnt;
    logic          gnt_dm;
    logic          dm_wins;

    // IF only overtakes DM once DM has won DM_STREAK_MAX times in a row against a waiting fetch.
    assign dm_wins   = dm_req && !(if_req && (streak == SW'(DM_STREAK_MAX)));
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state       <= IDLE;
            streak      <= '0;
            tcnt        <= '0;
            gnt_dm      <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= 4'h0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            if_ack      <= 1'b0;
            dm_ack      <= 1'b0;
            if_rdata    <= 32'h0;
            dm_rdata    <= 32'h0;
            timeout_err <= 1'b0;
        end else begin
            // A timeout setting the flag below overrides this clear in the same cycle.
            if (clear_err)
                timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (dm_req || if_req) begin
                        gnt_dm  <= dm_wins;
                        mem_req <= 1'b1;
                        tcnt    <= '0;
                        state   <= BUSY;
                        if (dm_wins) begin
                            mem_we    <= dm_we;
                            mem_be    <= dm_be;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            if (!if_req)
                                streak <= '0;
                            else if (streak != SW'(DM_STREAK_MAX))
                                streak <= streak + SW'(1);
                        end else begin
                            mem_we    <= 1'b0;
                            mem_be    <= 4'hF;
                            mem_addr  <= if_addr;
                            mem_wdata <= 32'h0;
                            streak    <= '0;
                        end
                    end
                end

                BUSY: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                        if (gnt_dm) begin
                            dm_rdata <= mem_rdata;
                            dm_ack   <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        mem_req     <= 1'b0;
                        tcnt        <= tcnt + TW'(1);
                        timeout_err <= 1'b1;
                        state       <= RESP;
                        if (gnt_dm) begin
                            dm_rdata <= 32'h0;
                            dm_ack   <= 1'b1;
                        end else begin
                            if_rdata <= 32'h0;
                            if_ack   <= 1'b1;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                RESP: begin
                    if_ack <= 1'b0;
                    dm_ack <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: drivers queue expected grants/read data, monitors pop and compare.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req, if_ack, dm_req, dm_we, dm_ack;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be, mem_be;
    logic        mem_req, mem_we, mem_ready, stall_if, stall_mem, clear_err, timeout_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    unified_mem_arbiter dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .clear_err(clear_err), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_t;

    gnt_t        if_gq[$], dm_gq[$];
    gnt_t        cur_g;
    bit          ord_q[$];
    logic [31:0] if_rq[$], dm_rq[$];
    bit          mon_o;

    int          n_chk = 0, n_err = 0;
    int          ready_delay = 0;
    bit          spurious = 1'b0;
    int          busy_cnt = 0, busy_len = 0;
    logic        prev_req = 1'b0, prev_if_ack = 1'b0, prev_dm_ack = 1'b0;
    logic [31:0] last_if_exp = 32'h0, last_dm_exp = 32'h0;
    int          if_ack_cnt = 0, dm_ack_cnt = 0, ack_before;
    int          last_lat_if = 0, last_lat_dm = 0;
    logic        last_err_if = 1'b0, last_err_dm = 1'b0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h40) ? 32'h00500093 : (a ^ 32'h3C3CA5A5);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Memory model plus grant and ack scoreboards.
    initial begin
        forever begin
            tick;
            if (mem_req) begin
                if (!prev_req) begin
                    if (ord_q.size() == 0) begin
                        chk("grant_spurious", 64'(mem_req), 64'(0));
                    end else begin
                        mon_o = ord_q.pop_front();
                        if (mon_o ? (dm_gq.size() == 0) : (if_gq.size() == 0)) begin
                            chk("grant_port_q", 64'(mon_o ? dm_gq.size() : if_gq.size()), 64'(1));
                        end else begin
                            cur_g = mon_o ? dm_gq.pop_front() : if_gq.pop_front();
                            chk("grant_we", 64'(mem_we), 64'(cur_g.we));
                            chk("grant_be", 64'(mem_be), 64'(cur_g.be));
                            chk("grant_addr", 64'(mem_addr), 64'(cur_g.addr));
                            if (cur_g.we)
                                chk("grant_wdata", 64'(mem_wdata), 64'(cur_g.wdata));
                        end
                    end
                end else begin
                    chk("mem_hold", 64'({mem_we, mem_be, mem_addr}), 64'({cur_g.we, cur_g.be, cur_g.addr}));
                end
                busy_cnt++;
                mem_ready = (busy_cnt > ready_delay);
                mem_rdata = mem_fn(mem_addr);
            end else begin
                if (prev_req)
                    busy_len = busy_cnt;
                busy_cnt  = 0;
                mem_ready = spurious;
                mem_rdata = 32'hBAD0BAD0;
            end

            if (if_ack) begin
                if_ack_cnt++;
                chk("if_ack_pulse", 64'(prev_if_ack), 64'(0));
                if (if_rq.size() == 0) begin
                    chk("if_ack_spurious", 64'(if_ack), 64'(0));
                end else begin
                    last_if_exp = if_rq.pop_front();
                    chk("if_rdata", 64'(if_rdata), 64'(last_if_exp));
                end
            end else begin
                chk("if_rdata_hold", 64'(if_rdata), 64'(last_if_exp));
            end

            if (dm_ack) begin
                dm_ack_cnt++;
                chk("dm_ack_pulse", 64'(prev_dm_ack), 64'(0));
                if (dm_rq.size() == 0) begin
                    chk("dm_ack_spurious", 64'(dm_ack), 64'(0));
                end else begin
                    last_dm_exp = dm_rq.pop_front();
                    chk("dm_rdata", 64'(dm_rdata), 64'(last_dm_exp));
                end
            end else begin
                chk("dm_rdata_hold", 64'(dm_rdata), 64'(last_dm_exp));
            end

            prev_req    = mem_req;
            prev_if_ack = if_ack;
            prev_dm_ack = dm_ack;
        end
    end

    // Issues n requests on one port, holding req high across acks (new payload presented in the ack cycle).
    task automatic run_port(input bit dm, input int n, input logic [31:0] base, input bit tmo);
        gnt_t        g;
        logic [31:0] a;
        int          lat;
        bit          got;
        logic        ack, stall;
        for (int i = 0; i < n; i++) begin
            a       = base + 32'(4 * i);
            g.we    = dm ? ~i[0] : 1'b0;
            g.be    = dm ? (4'hF ^ 4'(i)) : 4'hF;
            g.addr  = a;
            g.wdata = 32'hDEADBEEF + 32'(i);
            if (dm) begin
                dm_gq.push_back(g);
                dm_rq.push_back(tmo ? 32'h0 : mem_fn(a));
                dm_we = g.we; dm_be = g.be; dm_addr = a; dm_wdata = g.wdata; dm_req = 1'b1;
            end else begin
                if_gq.push_back(g);
                if_rq.push_back(tmo ? 32'h0 : mem_fn(a));
                if_addr = a; if_req = 1'b1;
            end
            lat = 0;
            got = 1'b0;
            while (!got && lat < 100) begin
                tick;
                lat++;
                ack   = dm ? dm_ack : if_ack;
                stall = dm ? stall_mem : stall_if;
                if (ack) begin
                    got = 1'b1;
                    chk(dm ? "stall_mem_at_ack" : "stall_if_at_ack", 64'(stall), 64'(0));
                end else begin
                    chk(dm ? "stall_mem_wait" : "stall_if_wait", 64'(stall), 64'(1));
                end
            end
            chk(dm ? "dm_ack_wait" : "if_ack_wait", 64'(got), 64'(1));
            if (dm) begin
                last_lat_dm = lat; last_err_dm = timeout_err;
            end else begin
                last_lat_if = lat; last_err_if = timeout_err;
            end
        end
        if (dm) dm_req = 1'b0;
        else    if_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
        clear_err = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mem_be", 64'(mem_be), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_if_ack", 64'(if_ack), 64'(0));
        chk("rst_dm_ack", 64'(dm_ack), 64'(0));
        chk("rst_if_rdata", 64'(if_rdata), 64'(0));
        chk("rst_dm_rdata", 64'(dm_rdata), 64'(0));
        chk("rst_timeout_err", 64'(timeout_err), 64'(0));
        chk("rst_stall_if", 64'(stall_if), 64'(0));
        chk("rst_stall_mem", 64'(stall_mem), 64'(0));
        resetn = 1'b0;
        tick;

        // Fetch only, minimum latency.
        ord_q.push_back(1'b0);
        run_port(1'b0, 1, 32'h40, 1'b0);
        chk("t1_if_lat", 64'(last_lat_if), 64'(2));
        chk("t1_if_rdata", 64'(if_rdata), 64'(32'h00500093));
        tick;

        // Simultaneous: DM write first, then IF.
        ord_q.push_back(1'b1);
        ord_q.push_back(1'b0);
        fork
            run_port(1'b1, 1, 32'h100, 1'b0);
            run_port(1'b0, 1, 32'h200, 1'b0);
        join
        chk("t2_dm_lat", 64'(last_lat_dm), 64'(2));
        chk("t2_if_lat", 64'(last_lat_if), 64'(5));
        tick;

        // Starvation guard: 4 DM grants then 1 IF, twice.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) ord_q.push_back(1'b1);
            ord_q.push_back(1'b0);
        end
        fork
            run_port(1'b1, 8, 32'h300, 1'b0);
            run_port(1'b0, 2, 32'h400, 1'b0);
        join
        tick;

        // Timeout with mem_ready never asserted.
        ready_delay = 1000;
        ord_q.push_back(1'b0);
        run_port(1'b0, 1, 32'h500, 1'b1);
        tick;
        chk("t4_busy_len", 64'(busy_len), 64'(15));
        chk("t4_if_lat", 64'(last_lat_if), 64'(16));
        chk("t4_err_at_ack", 64'(last_err_if), 64'(1));
        repeat (3) tick;
        chk("t4_err_sticky", 64'(timeout_err), 64'(1));
        clear_err = 1'b1;
        tick;
        clear_err = 1'b0;
        chk("t4_err_cleared", 64'(timeout_err), 64'(0));

        // mem_ready in the very cycle the timeout would fire wins.
        ready_delay = 14;
        ord_q.push_back(1'b1);
        run_port(1'b1, 1, 32'h600, 1'b0);
        tick;
        chk("t5_busy_len", 64'(busy_len), 64'(15));
        chk("t5_no_err", 64'(timeout_err), 64'(0));

        // Set and clear coincide: set wins for that cycle.
        ready_delay = 1000;
        clear_err = 1'b1;
        ord_q.push_back(1'b0);
        run_port(1'b0, 1, 32'h700, 1'b1);
        chk("t6_err_set_wins", 64'(last_err_if), 64'(1));
        tick;
        chk("t6_err_then_clear", 64'(timeout_err), 64'(0));
        clear_err = 1'b0;

        // Reset mid-BUSY with the error flag set.
        ord_q.push_back(1'b0);
        run_port(1'b0, 1, 32'h800, 1'b1);
        tick;
        chk("t7_err_pre", 64'(timeout_err), 64'(1));
        ord_q.push_back(1'b0);
        if_gq.push_back(gnt_t'{we: 1'b0, be: 4'hF, addr: 32'h900, wdata: 32'h0});
        if_addr = 32'h900;
        if_req  = 1'b1;
        repeat (4) tick;
        chk("t7_busy", 64'(mem_req), 64'(1));
        @(negedge clk);
        resetn      = 1'b1;
        last_if_exp = 32'h0;
        last_dm_exp = 32'h0;
        ack_before  = if_ack_cnt;
        #1;
        chk("t7_rst_mem_req", 64'(mem_req), 64'(0));
        chk("t7_rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("t7_rst_mem_be", 64'(mem_be), 64'(0));
        chk("t7_rst_err", 64'(timeout_err), 64'(0));
        chk("t7_rst_dm_rdata", 64'(dm_rdata), 64'(0));
        if_req = 1'b0;
        tick;
        @(negedge clk);
        resetn = 1'b0;
        repeat (4) tick;
        chk("t7_no_ack", 64'(if_ack_cnt - ack_before), 64'(0));
        ready_delay = 0;
        ord_q.push_back(1'b0);
        run_port(1'b0, 1, 32'h44, 1'b0);
        chk("t7_after_rst_lat", 64'(last_lat_if), 64'(2));
        tick;

        // Back-to-back DM with mem_ready stuck high outside BUSY.
        spurious = 1'b1;
        for (int k = 0; k < 3; k++) ord_q.push_back(1'b1);
        run_port(1'b1, 3, 32'hA00, 1'b0);
        chk("t8_dm_b2b_lat", 64'(last_lat_dm), 64'(3));
        repeat (4) tick;
        spurious = 1'b0;
        repeat (2) tick;

        chk("end_ord_q", 64'(ord_q.size()), 64'(0));
        chk("end_if_rq", 64'(if_rq.size()), 64'(0));
        chk("end_dm_rq", 64'(dm_rq.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
